// File: rtl/cpu_debug_host_scan.sv
// -----------------------------------------------------------------------------
// cpu_debug_host_scan
//
// Host-side initiator for the Nios II debug slave's virtual-JTAG interface.
// Takes one scan command (2-bit IR plus DR_WIDTH-bit payload). It then walks
// the virtual-JTAG states UIR -> CDR -> SDR -> UDR -> RTI while generating a
// divided TCK. The payload is shifted out on TDI (LSB first) and TDO is
// captured (first bit ends in the LSB). The captured word is returned on a
// valid/ready response channel.
//
// Ports:
//   clk, reset               system clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake; cmd_ready=1 only when idle
//   cmd_ir, cmd_data         instruction and payload, sampled on accept
//   rsp_valid / rsp_ready    response handshake
//   rsp_data                 word captured from vji_tdo
//   vji_tck, vji_tdi         divided test clock and serial data to the slave
//   vji_tdo                  serial data from the slave
//   vji_ir_in                instruction of the last accepted command
//   vji_uir/cdr/sdr/udr/rti  virtual-state strobes, one-hot while scanning
//
// Optional feature (macro DEBUG_SCAN_SKIP_IR_EN): when an accepted IR equals
// the IR of the previous completed scan, the UIR period is skipped.
// -----------------------------------------------------------------------------
module cpu_debug_host_scan #(
  parameter int DR_WIDTH    = 38,
  parameter int CLK_DIV     = 2,
  parameter int RTI_PERIODS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [1:0]          vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  // Period counter covers 2*CLK_DIV clk cycles (CLK_DIV <= 255 -> 9 bits).
  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] PER_LAST  = 9'(2 * CLK_DIV - 1);

  // One down-counter serves both the SDR bit count and the RTI period count.
  localparam int CNT_MAX = (DR_WIDTH > RTI_PERIODS) ? DR_WIDTH : RTI_PERIODS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(DR_WIDTH - 1);
  localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_PERIODS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [8:0]          div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DR_WIDTH-1:0] tx_q, tx_d;
  logic [DR_WIDTH-1:0] rx_q, rx_d;
  logic [1:0]          ir_q, ir_d;
  logic                ready_q, ready_d;
  logic                tck_q, tck_d;
  logic                scanning;
  logic                tck_rise;
  logic                period_end;

`ifdef DEBUG_SCAN_SKIP_IR_EN
  logic                skip_q, skip_d;
  logic                ir_valid_q, ir_valid_d;
`endif

  assign scanning   = (state_q == S_UIR) || (state_q == S_CDR) || (state_q == S_SDR) ||
                      (state_q == S_UDR) || (state_q == S_RTI);
  assign tck_rise   = scanning && (div_q == HALF_LAST);
  assign period_end = scanning && (div_q == PER_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    ir_d    = ir_q;
    ready_d = ready_q;
    tck_d   = 1'b0;
`ifdef DEBUG_SCAN_SKIP_IR_EN
    skip_d     = skip_q;
    ir_valid_d = ir_valid_q;
`endif

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (ready_q) begin
          if (cmd_valid) begin
            ir_d    = cmd_ir;
            tx_d    = cmd_data;
            rx_d    = '0;
            ready_d = 1'b0;
`ifdef DEBUG_SCAN_SKIP_IR_EN
            // ir_q still holds the IR of the previous scan at this point.
            skip_d  = ir_valid_q && (cmd_ir == ir_q);
`endif
          end
        end else begin
          // Command accepted last cycle: start the scan.
`ifdef DEBUG_SCAN_SKIP_IR_EN
          state_d = skip_q ? S_CDR : S_UIR;
`else
          state_d = S_UIR;
`endif
        end
      end

      S_UIR, S_CDR, S_SDR, S_UDR, S_RTI: begin
        div_d = period_end ? 9'd0 : div_q + 9'd1;
        if ((state_q == S_SDR) && tck_rise) begin
          rx_d = {vji_tdo, rx_q[DR_WIDTH-1:1]};
        end
        if (period_end) begin
          case (state_q)
            S_UIR: state_d = S_CDR;
            S_CDR: begin
              state_d = S_SDR;
              cnt_d   = SDR_LAST;
            end
            S_SDR: begin
              tx_d = tx_q >> 1;
              if (cnt_q == '0) begin
                state_d = S_UDR;
              end else begin
                cnt_d = cnt_q - 1'b1;
              end
            end
            S_UDR: begin
              state_d = S_RTI;
              cnt_d   = RTI_LAST;
            end
            default: begin // S_RTI
              if (cnt_q == '0) begin
                state_d = S_RESP;
              end else begin
                cnt_d = cnt_q - 1'b1;
              end
            end
          endcase
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
`ifdef DEBUG_SCAN_SKIP_IR_EN
          ir_valid_d = 1'b1;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase

    // TCK is registered so it is glitch-free; high in the second half-period.
    if ((state_d == S_UIR) || (state_d == S_CDR) || (state_d == S_SDR) ||
        (state_d == S_UDR) || (state_d == S_RTI)) begin
      tck_d = (div_d > HALF_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      ir_q    <= '0;
      ready_q <= 1'b1;
      tck_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ir_q    <= ir_d;
      ready_q <= ready_d;
      tck_q   <= tck_d;
    end
  end

`ifdef DEBUG_SCAN_SKIP_IR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_q     <= 1'b0;
      ir_valid_q <= 1'b0;
    end else begin
      skip_q     <= skip_d;
      ir_valid_q <= ir_valid_d;
    end
  end
`endif

  assign cmd_ready = ready_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rx_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = (state_q == S_SDR) && tx_q[0];
  assign vji_ir_in = ir_q;
  assign vji_uir   = (state_q == S_UIR);
  assign vji_cdr   = (state_q == S_CDR);
  assign vji_sdr   = (state_q == S_SDR);
  assign vji_udr   = (state_q == S_UDR);
  assign vji_rti   = (state_q == S_RTI);

endmodule

// File: tb/tb_cpu_debug_host_scan.sv
module tb_cpu_debug_host_scan;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [37:0] rsp_data;
  logic        vji_tck;
  logic        vji_tdi;
  logic        vji_tdo;
  logic [1:0]  vji_ir_in;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cpu_debug_host_scan dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .vji_tck   (vji_tck),
    .vji_tdi   (vji_tdi),
    .vji_tdo   (vji_tdo),
    .vji_ir_in (vji_ir_in),
    .vji_uir   (vji_uir),
    .vji_cdr   (vji_cdr),
    .vji_sdr   (vji_sdr),
    .vji_udr   (vji_udr),
    .vji_rti   (vji_rti)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Debug-slave model: 38-bit shift register, TDO = sr[0], shifts on TCK rise in SDR.
  logic [37:0] slv_sr;
  logic [37:0] slv_init;
  logic        slv_load;
  assign vji_tdo = slv_sr[0];
  always @(posedge vji_tck or posedge slv_load) begin
    if (slv_load) slv_sr <= slv_init;
    else if (vji_sdr) slv_sr <= {vji_tdi, slv_sr[37:1]};
  end

  task automatic preload(input logic [37:0] v);
    slv_init = v;
    slv_load = 1'b1;
    #1;
    slv_load = 1'b0;
  endtask

  // Issues one command with rsp_ready high and measures the scan.
  task automatic do_scan(input logic [1:0] ir, input logic [37:0] data,
                         output int lat, output int n_uir, output int n_cdr,
                         output int n_sdr, output int n_udr, output int n_rti,
                         output logic overlap, output logic ir_bad,
                         output logic [37:0] rsp, output logic [37:0] slv);
    bit done;
    int s;
    lat = -1; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
    overlap = 1'b0; ir_bad = 1'b0; rsp = '0; slv = '0; done = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 400 && !done; k++) begin
      @(negedge clk);
      s = int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr) + int'(vji_rti);
      if (s > 1) overlap = 1'b1;
      if (vji_ir_in !== ir) ir_bad = 1'b1;
      n_uir += int'(vji_uir); n_cdr += int'(vji_cdr); n_sdr += int'(vji_sdr);
      n_udr += int'(vji_udr); n_rti += int'(vji_rti);
      if (rsp_valid === 1'b1) begin
        lat = k; rsp = rsp_data; slv = slv_sr; done = 1;
      end
    end
    @(negedge clk); // handshake edge passed
  endtask

  task automatic test_reset;
    logic tck_moved;
    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_data = '0; rsp_ready = 1'b0;
    slv_load = 1'b0; slv_init = '0;
    preload(38'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if ({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 9'd0)
      $display("FAIL reset_vji got %b want 0",
               {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
    else pass_cnt++;
    total_cnt++;
    if (rsp_data !== 38'h0) $display("FAIL reset_rsp_data got %h want 0", rsp_data);
    else pass_cnt++;
    tck_moved = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vji_tck !== 1'b0 || cmd_ready !== 1'b1) tck_moved = 1'b1;
    end
    total_cnt++;
    if (tck_moved !== 1'b0) $display("FAIL idle_static got %b want 0", tck_moved);
    else pass_cnt++;
    $display("reset/idle: cmd_ready=%b tck=%b", cmd_ready, vji_tck);
  endtask

  task automatic test_loopback;
    int lat, a, b, c, d, e;
    logic ov, irb;
    logic [37:0] rsp, slv;
    preload(38'h2A_5A5A_5A5A);
    do_scan(2'b01, 38'h15_0F0F_0F0F, lat, a, b, c, d, e, ov, irb, rsp, slv);
    $display("loopback: rsp=%h slave=%h latency=%0d", rsp, slv, lat);
    total_cnt++;
    if (rsp !== 38'h2A_5A5A_5A5A) $display("FAIL loop_rsp got %h want 2a5a5a5a5a", rsp);
    else pass_cnt++;
    total_cnt++;
    if (slv !== 38'h15_0F0F_0F0F) $display("FAIL loop_slave got %h want 150f0f0f0f", slv);
    else pass_cnt++;
    total_cnt++;
    if (lat != 169) $display("FAIL loop_latency got %0d want 169", lat);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL loop_after_hs got rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_strobes;
    int lat, nu, nc, ns, nd, nr;
    logic ov, irb;
    logic [37:0] rsp, slv;
    preload(38'h00_1234_ABCD);
    do_scan(2'b01, 38'h3F_FFFF_0000, lat, nu, nc, ns, nd, nr, ov, irb, rsp, slv);
    $display("strobes: uir=%0d cdr=%0d sdr=%0d udr=%0d rti=%0d overlap=%b irbad=%b",
             nu, nc, ns, nd, nr, ov, irb);
    total_cnt++;
    if (nu != 4 || nc != 4 || nd != 4 || nr != 4)
      $display("FAIL strobe_short got uir=%0d cdr=%0d udr=%0d rti=%0d want 4 each", nu, nc, nd, nr);
    else pass_cnt++;
    total_cnt++;
    if (ns != 152) $display("FAIL strobe_sdr got %0d want 152", ns);
    else pass_cnt++;
    total_cnt++;
    if (ov !== 1'b0) $display("FAIL strobe_overlap got %b want 0", ov);
    else pass_cnt++;
    total_cnt++;
    if (irb !== 1'b0) $display("FAIL strobe_ir_in got %b want 0", irb);
    else pass_cnt++;
    total_cnt++;
    if (rsp !== 38'h00_1234_ABCD || slv !== 38'h3F_FFFF_0000)
      $display("FAIL strobe_data got rsp=%h slave=%h want 001234abcd/3fffff0000", rsp, slv);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic busy_bad, hold_bad, extra_scan, seen;
    logic [37:0] first;
    busy_bad = 1'b0; hold_bad = 1'b0; extra_scan = 1'b0; seen = 1'b0; first = '0;
    preload(38'h01_2345_6789);
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_ir = 2'b11; cmd_data = 38'h3A_BCDE_F012; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 400 && !seen; k++) begin
      @(negedge clk);
      if (k == 50 || k == 51) begin
        cmd_valid = 1'b1; cmd_ir = 2'b00; cmd_data = 38'h00_DEAD_BEEF;
        if (vji_sdr !== 1'b1 || cmd_ready !== 1'b0) busy_bad = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      if (rsp_valid === 1'b1) begin
        seen = 1'b1; first = rsp_data;
      end
    end
    total_cnt++;
    if (first !== 38'h01_2345_6789 || seen !== 1'b1)
      $display("FAIL bp_rsp got %h seen=%b want 0123456789", first, seen);
    else pass_cnt++;
    total_cnt++;
    if (busy_bad !== 1'b0) $display("FAIL bp_busy_pulse got %b want 0", busy_bad);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== first || cmd_ready !== 1'b0) hold_bad = 1'b1;
    end
    total_cnt++;
    if (hold_bad !== 1'b0) $display("FAIL bp_hold got %b want 0", hold_bad);
    else pass_cnt++;
    rsp_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL bp_release got rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vji_uir | vji_cdr | vji_sdr | vji_udr | vji_rti | rsp_valid) extra_scan = 1'b1;
    end
    total_cnt++;
    if (extra_scan !== 1'b0) $display("FAIL bp_no_second_scan got %b want 0", extra_scan);
    else pass_cnt++;
    $display("backpressure: rsp=%h hold_bad=%b extra=%b", first, hold_bad, extra_scan);
  endtask

  task automatic test_reset_abort;
    int lat, a, b, c, d, e;
    logic ov, irb, leak;
    logic [37:0] rsp, slv;
    preload(38'h2A_5A5A_5A5A);
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_ir = 2'b10; cmd_data = 38'h15_0F0F_0F0F; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    // SDR starts 9 edges after accept; bit 17 covers edges 77..80.
    repeat (79) @(negedge clk);
    total_cnt++;
    if (vji_sdr !== 1'b1) $display("FAIL abort_in_sdr got %b want 1", vji_sdr);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr,
         vji_udr, vji_rti} !== 11'b100_0000_0000)
      $display("FAIL abort_async got %b want 10000000000",
               {cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr,
                vji_udr, vji_rti});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    leak = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid | vji_sdr | vji_tck | ~cmd_ready) leak = 1'b1;
    end
    total_cnt++;
    if (leak !== 1'b0) $display("FAIL abort_no_rsp got %b want 0", leak);
    else pass_cnt++;
    preload(38'h0A_A55A_3CC3);
    do_scan(2'b01, 38'h35_1122_3344, lat, a, b, c, d, e, ov, irb, rsp, slv);
    total_cnt++;
    if (rsp !== 38'h0A_A55A_3CC3 || slv !== 38'h35_1122_3344)
      $display("FAIL abort_recover got rsp=%h slave=%h want 0aa55a3cc3/3511223344", rsp, slv);
    else pass_cnt++;
    total_cnt++;
    if (lat != 169 || a != 4) $display("FAIL abort_recover_lat got lat=%0d uir=%0d want 169/4", lat, a);
    else pass_cnt++;
    $display("reset abort: recovered rsp=%h latency=%0d", rsp, lat);
  endtask

  task automatic test_repeat_ir;
    int lat1, lat2, u1, u2, b, c, d, e;
    logic ov, irb;
    logic [37:0] rsp1, rsp2, slv;
    preload(38'h11_2233_4455);
    do_scan(2'b10, 38'h01_0203_0405, lat1, u1, b, c, d, e, ov, irb, rsp1, slv);
    preload(38'h2F_EDCB_A987);
    do_scan(2'b10, 38'h06_0708_090A, lat2, u2, b, c, d, e, ov, irb, rsp2, slv);
    $display("repeat ir: lat1=%0d uir1=%0d lat2=%0d uir2=%0d", lat1, u1, lat2, u2);
    total_cnt++;
    if (lat1 != 169 || u1 != 4) $display("FAIL rep_first got lat=%0d uir=%0d want 169/4", lat1, u1);
    else pass_cnt++;
`ifdef DEBUG_SCAN_SKIP_IR_EN
    total_cnt++;
    if (lat2 != 165 || u2 != 0) $display("FAIL rep_second got lat=%0d uir=%0d want 165/0", lat2, u2);
    else pass_cnt++;
`else
    total_cnt++;
    if (lat2 != 169 || u2 != 4) $display("FAIL rep_second got lat=%0d uir=%0d want 169/4", lat2, u2);
    else pass_cnt++;
`endif
    total_cnt++;
    if (rsp1 !== 38'h11_2233_4455 || rsp2 !== 38'h2F_EDCB_A987)
      $display("FAIL rep_data got %h/%h want 1122334455/2fedcba987", rsp1, rsp2);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_strobes;
    test_backpressure;
    test_reset_abort;
    test_repeat_ir;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
